// File: rtl/state_frame_encoder.sv
// Framed serial encoder: start bit, STATE_LENGTH data bits, optional even parity, then idle.
// Optional parity stage is enabled by defining STATE_ENC_PARITY_EN.
module state_frame_encoder #(
  parameter int STATE_LENGTH = 14,
  parameter int BIT_PERIOD   = 1,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit IDLE_LEVEL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [STATE_LENGTH-1:0] state,
  input  logic                    enable,
  output logic                    out,
  output logic                    busy,
  output logic                    done
);

  localparam int BIT_W = (STATE_LENGTH > 1) ? $clog2(STATE_LENGTH) : 1;
  localparam int PER_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(STATE_LENGTH - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef STATE_ENC_PARITY_EN
    PARITY = 3'd3,
`endif
    DONE   = 3'd4
  } fsm_t;

  fsm_t                    st_q, st_d;
  logic                    enable_q;
  logic [STATE_LENGTH-1:0] shreg;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PER_W-1:0]        per_cnt;
  logic                    trig;
  logic                    per_end;
  logic                    in_frame;

  assign trig     = enable & ~enable_q;
  assign per_end  = (per_cnt == PER_LAST);
  assign in_frame = busy;

`ifdef STATE_ENC_PARITY_EN
  logic parity_q;

  // Parity is taken from the word at capture, so later state changes cannot affect it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    parity_q <= 1'b0;
    else if (st_q == IDLE && trig) parity_q <= ^state;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      enable_q <= 1'b1;  // a level-high enable across reset release must not trigger
      shreg    <= '0;
      bit_cnt  <= '0;
      per_cnt  <= '0;
    end else begin
      st_q     <= st_d;
      enable_q <= enable;

      if (in_frame) per_cnt <= per_end ? '0 : per_cnt + 1'b1;
      else          per_cnt <= '0;

      if (st_q == DATA) begin
        if (per_end) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end

      if (st_q == IDLE && trig)
        shreg <= state;
      else if (st_q == DATA && per_end)
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end
  end

  always_comb begin
    st_d = st_q;
    out  = IDLE_LEVEL;
    busy = 1'b0;
    done = 1'b0;
    case (st_q)
      IDLE: begin
        if (trig) st_d = START;
      end
      START: begin
        busy = 1'b1;
        out  = ~IDLE_LEVEL;
        if (per_end) st_d = DATA;
      end
      DATA: begin
        busy = 1'b1;
        out  = MSB_FIRST ? shreg[STATE_LENGTH-1] : shreg[0];
        if (per_end && bit_cnt == BIT_LAST) begin
`ifdef STATE_ENC_PARITY_EN
          st_d = PARITY;
`else
          st_d = DONE;
`endif
        end
      end
`ifdef STATE_ENC_PARITY_EN
      PARITY: begin
        busy = 1'b1;
        out  = parity_q;
        if (per_end) st_d = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_state_frame_encoder.sv
// Scoreboard bench: per-cycle {out,busy,done} expectations are queued when a frame is
// triggered and popped each cycle. Two instances cover MSB/period-1 and LSB/period-3.
module tb_state_frame_encoder;

`ifdef STATE_ENC_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] st_a, st_b;
  logic        en_a, en_b;
  logic        out_a, busy_a, done_a;
  logic        out_b, busy_b, done_b;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  state_frame_encoder u_a (
    .clk(clk), .reset(reset), .state(st_a), .enable(en_a),
    .out(out_a), .busy(busy_a), .done(done_a)
  );

  state_frame_encoder #(
    .STATE_LENGTH(14), .BIT_PERIOD(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .state(st_b), .enable(en_b),
    .out(out_b), .busy(busy_b), .done(done_b)
  );

  // Reference frame model: one entry per cycle after the trigger edge.
  task automatic push_frame(input logic [13:0] s, input int bp, input bit msb);
    logic b;
    for (int k = 0; k < bp; k++) exp_q.push_back(3'b110);
    for (int i = 0; i < 14; i++) begin
      b = msb ? s[13-i] : s[i];
      for (int k = 0; k < bp; k++) exp_q.push_back({b, 2'b10});
    end
    if (PAR) begin
      b = ^s;
      for (int k = 0; k < bp; k++) exp_q.push_back({b, 2'b10});
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(3'b000);
  endtask

  task automatic quiesce_a();
    @(negedge clk); en_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] oa, ob;
    reset = 1'b1; en_a = 1'b1; en_b = 1'b1; st_a = 14'h3FFF; st_b = 14'h3FFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      oa = {out_a, busy_a, done_a};
      ob = {out_b, busy_b, done_b};
      vectors += 2;
      if (oa !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold_a cycle %0d: got %b want 000", c, oa);
      end
      if (ob !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_hold_b cycle %0d: got %b want 000", c, ob);
      end
    end
    en_b = 1'b0;
    quiesce_a();
  endtask

  task automatic test_msb_frame();
    logic [2:0] obs, e;
    int n;
    st_a = 14'h0330;
    en_a = 1'b1;
    push_frame(14'h0330, 1, 1'b1);
    push_idle(6);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL msb_frame cycle %0d: got %b want %b", c, obs, e);
      end
      if (c == 3) st_a = 14'h3CCF;  // must not disturb the frame in flight
    end
    quiesce_a();
  endtask

  task automatic test_retrigger();
    logic [2:0] obs, e;
    int n;
    st_a = 14'h0330;
    en_a = 1'b1;
    push_frame(14'h0330, 1, 1'b1);
    push_idle(10);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL retrigger cycle %0d: got %b want %b", c, obs, e);
      end
      if (c == 6) en_a = 1'b0;
      if (c == 7) en_a = 1'b1;
    end
    quiesce_a();
  endtask

  task automatic test_done_retrigger();
    logic [2:0] obs, e;
    int n, d;
    d = 16 + (PAR ? 1 : 0);
    st_a = 14'h2A5B;
    en_a = 1'b1;
    push_frame(14'h2A5B, 1, 1'b1);
    push_idle(8);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL done_retrigger cycle %0d: got %b want %b", c, obs, e);
      end
      if (c == d - 1) en_a = 1'b0;
      if (c == d)     en_a = 1'b1;  // edge sampled in DONE: ignored
    end
    quiesce_a();
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, e;
    int n, d;
    d = 16 + (PAR ? 1 : 0);
    st_a = 14'h1111;
    en_a = 1'b1;
    push_frame(14'h1111, 1, 1'b1);
    push_idle(1);
    push_frame(14'h0E0E, 1, 1'b1);
    push_idle(4);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs, e);
      end
      if (c == d) begin
        en_a = 1'b0;
        st_a = 14'h0E0E;
      end
      if (c == d + 1) en_a = 1'b1;  // edge sampled in first IDLE cycle
    end
    quiesce_a();
  endtask

  task automatic test_lsb_period3();
    logic [2:0] obs, e;
    int n;
    st_b = 14'h00C9;
    en_b = 1'b1;
    push_frame(14'h00C9, 3, 1'b0);
    push_idle(6);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_b, busy_b, done_b};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL lsb_period3 cycle %0d: got %b want %b", c, obs, e);
      end
      if (c == 5) st_b = 14'h3FFF;
    end
    @(negedge clk); en_b = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [2:0] obs, e;
    int n;
    st_a = 14'h2A5B;
    en_a = 1'b1;
    push_frame(14'h2A5B, 1, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL midframe_pre cycle %0d: got %b want %b", c, obs, e);
      end
    end
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    obs = {out_a, busy_a, done_a};
    vectors++;
    if (obs !== 3'b000) begin
      miscompares++;
      $display("FAIL midframe_async_reset: got %b want 000", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      vectors++;
      if (obs !== 3'b000) begin
        miscompares++;
        $display("FAIL midframe_post_release cycle %0d: got %b want 000", c, obs);
      end
    end
    quiesce_a();
    st_a = 14'h1234;
    en_a = 1'b1;
    push_frame(14'h1234, 1, 1'b1);
    push_idle(3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs = {out_a, busy_a, done_a};
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL midframe_fresh cycle %0d: got %b want %b", c, obs, e);
      end
    end
    quiesce_a();
  endtask

  task automatic test_parity();
    logic [2:0] obs, e;
    int n;
    for (int t = 0; t < 2; t++) begin
      st_a = (t == 0) ? 14'h0330 : 14'h0331;
      en_a = 1'b1;
      push_frame(st_a, 1, 1'b1);
      push_idle(3);
      n = exp_q.size();
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        obs = {out_a, busy_a, done_a};
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL parity_%0d cycle %0d: got %b want %b", t, c, obs, e);
        end
      end
      quiesce_a();
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_retrigger();
    test_done_retrigger();
    test_back_to_back();
    test_lsb_period3();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
